// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle from vga_sync_gen to the pixel-drawing logic.
// master drives, slave observes.
interface vga_sync_gen_if;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic       video;
  logic       hsync;
  logic       vsync;
  logic       pix_tick;
  logic       frame_tick;

  modport master (
    output h_count, v_count, video,
    output hsync, vsync,
    output pix_tick, frame_tick
  );

  modport slave (
    input h_count, v_count, video,
    input hsync, vsync,
    input pix_tick, frame_tick
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: divided pixel rate, h/v counters,
// sync/video decode delayed to line up with downstream ROM data.
module vga_sync_gen #(
  parameter int CLK_DIV    = 2,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_POL   = 0,
  parameter int SYNC_DELAY = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_ON  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_ON  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [2:0] DIV_LAST = 3'(CLK_DIV - 1);
  localparam logic       S_ON     = 1'(SYNC_POL);
  localparam logic       S_OFF    = ~S_ON;

  logic [2:0] div;
  logic       adv;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [9:0] h_nxt;
  logic [9:0] v_nxt;
  logic       hs_raw;
  logic       vs_raw;
  logic       vid_raw;
  logic       pix_q;
  logic       frame_q;

  // Stage 0 holds the decode aligned with the counters; the last
  // stage is what leaves the block.
  logic hs_q  [0:SYNC_DELAY];
  logic vs_q  [0:SYNC_DELAY];
  logic vid_q [0:SYNC_DELAY];

  assign adv = (div == DIV_LAST);

  always_comb begin
    h_nxt = h_cnt + 10'd1;
    v_nxt = v_cnt;
    if (h_cnt == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end
  end

  always_comb begin
    hs_raw  = (h_nxt >= HS_ON) && (h_nxt < HS_END);
    vs_raw  = (v_nxt >= VS_ON) && (v_nxt < VS_END);
    vid_raw = (h_nxt < H_ACT) && (v_nxt < V_ACT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div     <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
      pix_q   <= 1'b0;
      frame_q <= 1'b0;
      for (int i = 0; i <= SYNC_DELAY; i++) begin
        hs_q[i]  <= S_OFF;
        vs_q[i]  <= S_OFF;
        vid_q[i] <= 1'b0;
      end
    end else begin
      div     <= adv ? '0 : div + 3'd1;
      pix_q   <= adv;
      frame_q <= adv && (h_nxt == '0) && (v_nxt == V_ACT);
      if (adv) begin
        h_cnt    <= h_nxt;
        v_cnt    <= v_nxt;
        hs_q[0]  <= hs_raw ? S_ON : S_OFF;
        vs_q[0]  <= vs_raw ? S_ON : S_OFF;
        vid_q[0] <= vid_raw;
        for (int i = 1; i <= SYNC_DELAY; i++) begin
          hs_q[i]  <= hs_q[i-1];
          vs_q[i]  <= vs_q[i-1];
          vid_q[i] <= vid_q[i-1];
        end
      end
    end
  end

  assign vga.h_count    = h_cnt;
  assign vga.v_count    = v_cnt;
  assign vga.pix_tick   = pix_q;
  assign vga.frame_tick = frame_q;
  assign vga.hsync      = hs_q[SYNC_DELAY];
  assign vga.vsync      = vs_q[SYNC_DELAY];
  assign vga.video      = vid_q[SYNC_DELAY];

endmodule
